// File: rtl/exe_muldiv_unit.sv
// Multiply/divide unit for the EXE stage: pipelined multiply, radix-2 restoring divide,
// architectural HI/LO registers, and a flush input that cancels in-flight work.
module exe_muldiv_unit #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_hi,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_MAX = (DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              sig_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dvs_r;

    logic              accept;
    logic [2*DATA_W-1:0] a_x;
    logic [2*DATA_W-1:0] b_x;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] mul_out;

    logic [DATA_W:0]   div_tmp;
    logic              div_ge;
    logic [DATA_W-1:0] div_sub;
    logic              div_zero;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] fix_hi;
    logic [DATA_W-1:0] fix_lo;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? -v : v;
    endfunction

    assign req_ready = (state == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready && !flush;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !flush;

    // Extending to the full product width makes the low 2*DATA_W bits correct for both signednesses.
    assign a_x  = {{DATA_W{sig_r & a_r[DATA_W-1]}}, a_r};
    assign b_x  = {{DATA_W{sig_r & b_r[DATA_W-1]}}, b_r};
    assign prod = a_x * b_x;

    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_out = prod;
        end else begin : g_mul_pipe
            logic [2*DATA_W-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                pipe[0] <= prod;
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign mul_out = pipe[MUL_STAGES-2];
        end
    endgenerate

    // The partial remainder stays below the divisor, so a set top bit of the shifted value
    // always means "subtract", and the W-bit difference is exact.
    assign div_tmp = {rem_r, quo_r[DATA_W-1]};
    assign div_ge  = div_tmp[DATA_W] || (div_tmp[DATA_W-1:0] >= dvs_r);
    assign div_sub = div_tmp[DATA_W-1:0] - dvs_r;

    assign div_zero = (b_r == '0);
    assign neg_q    = sig_r && (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
    assign neg_r    = sig_r && a_r[DATA_W-1];
    assign fix_lo   = div_zero ? '1  : (neg_q ? -quo_r : quo_r);
    assign fix_hi   = div_zero ? a_r : (neg_r ? -rem_r : rem_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sig_r     <= 1'b0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            result_hi <= '0;
            result_lo <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MULT, OP_MULTU: begin
                                a_r   <= req_src1;
                                b_r   <= req_src2;
                                sig_r <= (req_op == OP_MULT);
                                cnt   <= '0;
                                state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_r   <= req_src1;
                                b_r   <= req_src2;
                                sig_r <= (req_op == OP_DIV);
                                rem_r <= '0;
                                quo_r <= mag(req_src1, req_op == OP_DIV);
                                dvs_r <= mag(req_src2, req_op == OP_DIV);
                                cnt   <= '0;
                                state <= S_DIV_RUN;
                            end
                            OP_MTHI: hi <= req_src1;
                            OP_MTLO: lo <= req_src1;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == MUL_LAST) begin
                            result_hi <= mul_out[2*DATA_W-1:DATA_W];
                            result_lo <= mul_out[DATA_W-1:0];
                            state     <= S_DONE;
                        end
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_r <= div_ge ? div_sub : div_tmp[DATA_W-1:0];
                        quo_r <= {quo_r[DATA_W-2:0], div_ge};
                        cnt   <= cnt + 1'b1;
                        if (cnt == DIV_LAST) begin
                            state <= S_DIV_FIX;
                        end
                    end
                end
                S_DIV_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result_hi <= fix_hi;
                        result_lo <= fix_lo;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        hi <= result_hi;
                        lo <= result_lo;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: a driver pushes expected {done cycle, hi, lo} into a
// queue and a negedge monitor pops and compares on every done pulse.
module tb_exe_muldiv_unit;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_src1;
    logic [W-1:0] req_src2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    exe_muldiv_unit #(.DATA_W(W), .MUL_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .hi        (hi),
        .lo        (lo)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [3*W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    logic         pend = 1'b0;
    logic [W-1:0] ph;
    logic [W-1:0] pl;
    always @(negedge clk) begin
        if (!reset) begin
            if (pend) begin
                chk("arch_hi", 64'(hi), 64'(ph));
                chk("arch_lo", 64'(lo), 64'(pl));
                pend = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: hi=%h lo=%h with no pending op (cycle %0d)",
                             result_hi, result_lo, cyc);
                end else begin
                    logic [3*W-1:0] e;
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e[3*W-1:2*W]));
                    chk("result_hi", 64'(result_hi), 64'(e[2*W-1:W]));
                    chk("result_lo", 64'(result_lo), 64'(e[W-1:0]));
                    pend = 1'b1;
                    ph   = e[2*W-1:W];
                    pl   = e[W-1:0];
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int t);
        int  k   = 0;
        bit  got = 1'b0;
        t         = -1;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        while (!got && k < 200) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                t   = cyc;
            end
            @(posedge clk);
            #1;
            k++;
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d not accepted in 200 cycles", op);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat);
        int t;
        issue(op, a, b, t);
        if (t >= 0) begin
            exp_q.push_back({32'(t + lat), ehi, elo});
            m_hi = ehi;
            m_lo = elo;
        end
    endtask

    task automatic drain();
        int k   = 0;
        bit fin = 1'b0;
        while (!fin && k < 400) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) fin = 1'b1;
            k++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, busy=%0b", exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam int LM = 3;   // MUL_STAGES + 1
    localparam int LD = 34;  // DATA_W + 2

    initial begin
        int t;
        int t1;
        int t2;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        flush     = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);
        chk("busy_after_reset", 64'(busy), 64'd0);
        chk("done_after_reset", 64'(done), 64'd0);
        chk("hi_after_reset", 64'(hi), 64'd0);
        chk("lo_after_reset", 64'(lo), 64'd0);
        chk("rhi_after_reset", 64'(result_hi), 64'd0);
        chk("rlo_after_reset", 64'(result_lo), 64'd0);
        @(posedge clk);
        #1;

        // multiply / divide vectors, issued back to back
        run(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LM);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LM);
        run(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LM);
        run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LD);
        run(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        LD);
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LD);
        run(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, LD);
        run(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, LD);
        run(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, LD);
        drain();

        // flush during divide
        issue(OP_DIVU, 32'd100, 32'd7, t);
        wait_cyc(t + 10);
        flush = 1'b1;
        @(negedge clk);
        chk("busy_before_flush", 64'(busy), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_div_idle_cycle", 64'(cyc), 64'(t + 11));
        chk("flush_div_busy", 64'(busy), 64'd0);
        chk("flush_div_ready", 64'(req_ready), 64'd1);
        chk("flush_div_hi", 64'(hi), 64'(m_hi));
        chk("flush_div_lo", 64'(lo), 64'(m_lo));
        repeat (40) @(posedge clk);
        #1;

        // flush in the DONE cycle
        issue(OP_MULT, 32'd6, 32'd7, t);
        wait_cyc(t + 3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_busy", 64'(busy), 64'd1);
        chk("flush_done_pulse", 64'(done), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_done_idle", 64'(busy), 64'd0);
        chk("flush_done_hi", 64'(hi), 64'(m_hi));
        chk("flush_done_lo", 64'(lo), 64'(m_lo));
        @(posedge clk);
        #1;

        // flush together with a request
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = OP_MTLO;
        req_src1  = 32'h0000_ABCD;
        @(posedge clk);
        #1 req_op = OP_DIV;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk("flush_req_lo", 64'(lo), 64'(m_lo));
        chk("flush_req_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // reserved ops are no-ops
        issue(3'd6, 32'h55, 32'h66, t);
        @(negedge clk);
        chk("op6_busy", 64'(busy), 64'd0);
        issue(3'd7, 32'h77, 32'h88, t);
        @(negedge clk);
        chk("op7_busy", 64'(busy), 64'd0);
        chk("op67_hi", 64'(hi), 64'(m_hi));
        chk("op67_lo", 64'(lo), 64'(m_lo));
        repeat (5) @(posedge clk);
        #1;

        // MTLO visible the cycle after acceptance
        issue(OP_MTLO, 32'h0000_BEEF, 32'd0, t);
        m_lo = 32'h0000_BEEF;
        @(negedge clk);
        chk("mtlo_lo", 64'(lo), 64'h0000_BEEF);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // MTHI then MULT with no gap
        issue(OP_MTHI, 32'h0000_1234, 32'd0, t1);
        issue(OP_MULT, 32'h10, 32'h20, t2);
        chk("mthi_mult_gap", 64'(t2), 64'(t1 + 1));
        exp_q.push_back({32'(t2 + LM), 32'h0, 32'h200});
        m_hi = 32'h0;
        m_lo = 32'h200;
        @(negedge clk);
        chk("mul_ready_1", 64'(req_ready), 64'd0);
        chk("mthi_hi_1", 64'(hi), 64'h1234);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mul_ready_2", 64'(req_ready), 64'd0);
        chk("mthi_hi_2", 64'(hi), 64'h1234);
        drain();

        // back-to-back multiplies
        issue(OP_MULTU, 32'd3, 32'd4, t1);
        exp_q.push_back({32'(t1 + LM), 32'd0, 32'd12});
        issue(OP_MULTU, 32'd5, 32'd6, t2);
        exp_q.push_back({32'(t2 + LM), 32'd0, 32'd30});
        chk("b2b_accept", 64'(t2), 64'(t1 + LM + 1));
        m_hi = 32'd0;
        m_lo = 32'd30;
        drain();

        // reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7, t);
        wait_cyc(t + 6);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_ready", 64'(req_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
